regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the 16-entry CPU register file: configurable width and depth, optional hardwired zero register, and write-to-read bypass.
- Adds a per-register pending-write scoreboard for load/multi-cycle hazard detection.
- Adds a sequenced clear after reset, so large depths do not need a single-cycle reset fan-out.
- Sits in the decode stage. It feeds operand registers A/B and stall hints to the control unit.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; fixed at 5 for the MIPS rs/rt/rd fields.
- DEPTH, 32, number of implemented registers, 2..2^ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and reservations.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- rd  input  ADDR_W  write address.
- dataIn  input  DATA_W  write data.
- rs  input  ADDR_W  read address, port A.
- rt  input  ADDR_W  read address, port B.
- rsv  input  1  reserve request: mark a destination as pending.
- rsv_addr  input  ADDR_W  register to reserve.
- regA  output  DATA_W  registered read data for rs.
- regB  output  DATA_W  registered read data for rt.
- hazA  output  1  combinational: rs has a pending write.
- hazB  output  1  combinational: rt has a pending write.
- ready  output  1  high once the clear sequence has finished.

Behaviour:
- Reset, when rst=1 at a clock edge:
  - regA=0, regB=0, ready=0.
  - All pending bits are 0.
  - FSM goes to CLEAR with clr_idx=0.
  - rst takes priority over every other input, including mid-CLEAR (clr_idx restarts at 0).
- FSM states:
  - CLEAR: each cycle writes 0 to register[clr_idx] and increments clr_idx. After clr_idx=DEPTH-1 is written, go to RUN; ready=1 from the next cycle. CLEAR lasts exactly DEPTH cycles.
  - RUN: stays in RUN until rst.
- During CLEAR:
  - we and rsv are ignored.
  - regA/regB load 0.
  - hazA/hazB = 0.
- Write (RUN only): if we and rd<DEPTH and not (ZERO_REG and rd==0), then register[rd] <= dataIn at the edge.
- Read, latency 1 cycle (regA/regB are registered):
  - regA <= 0 if rs>=DEPTH or (ZERO_REG and rs==0).
  - Otherwise regA <= dataIn if the write above is active with rd==rs (write-first bypass).
  - Otherwise regA <= register[rs].
  - regB follows the same rules with rt.
- Scoreboard, pending[DEPTH-1:0], RUN only:
  - A qualifying write (same conditions as above) clears pending[rd].
  - rsv with rsv_addr<DEPTH and not (ZERO_REG and rsv_addr==0) sets pending[rsv_addr].
  - rsv and write to the same address in the same cycle: set wins, because the reservation is a new producer.
  - A reservation to an already-pending register keeps the bit at 1; there is no counting.
- Hazard outputs:
  - hazA = pending[rs] AND NOT (active write with rd==rs). The same-cycle bypass resolves the hazard.
  - hazA = 0 for an out-of-range rs or a zero-register rs.
  - hazB follows the same rules with rt.
- Out-of-range addresses (>=DEPTH) never alias: they wrap to nothing, are discarded on write and read as 0.
- No X propagation: every register element is written during CLEAR before ready=1.

Decomposition:
- Shared package (regfile_pkg) holds:
  - state encoding ST_CLEAR and ST_RUN;
  - a function computing the valid-and-not-zero qualifier for an address, given DEPTH and ZERO_REG.
- One sub-module is natural: regfile_scoreboard. It owns the pending vector, the set/clear priority and the hazard outputs. The parent keeps the storage, bypass and CLEAR FSM.

Test Plan:
- Assert rst for 1 cycle, DEPTH=32 -> ready=0 for 32 cycles then 1. regA=regB=0 throughout. A read of r5 after ready returns 0.
- RUN, we=1, rd=5, dataIn=0xDEADBEEF, rs=5 in the same cycle -> regA=0xDEADBEEF next cycle (bypass). A later read of rs=5 also gives 0xDEADBEEF.
- ZERO_REG=1: write rd=0 with 0x1234, rsv rsv_addr=0 -> a read of rs=0 gives 0 and hazA=0. With DEPTH=16, a write to rd=20 is discarded and a read of rt=20 gives 0.
- rsv rsv_addr=7 -> rs=7 gives hazA=1 next cycle. Then we rd=7 with 0x55 -> hazA=0 in that same cycle. pending[7]=0 after the edge, and regA=0x55.
- Same cycle rsv rsv_addr=9 and we rd=9 with 0xAA -> register[9]=0xAA, pending[9] stays 1, and hazB (rt=9) is 1 the next cycle.
- Assert rst at clear cycle 10, then release -> clear restarts. ready rises exactly DEPTH cycles after the release, and we/rsv pulses during CLEAR have no effect.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared state encoding and address qualifier for the scoreboarded register file.
package regfile_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   // An address is live when it maps to an implemented register that is not the hardwired zero.
   function automatic logic addr_live(input int addr, input int depth, input logic zero_reg);
      return (addr < depth) && !(zero_reg && (addr == 0));
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, reservation beats same-cycle write clear.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_i,
   input  logic              wr_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic              rsv_i,
   input  logic [ADDR_W-1:0] rsv_addr_i,
   input  logic [ADDR_W-1:0] rs_i,
   input  logic [ADDR_W-1:0] rt_i,
   output logic              haz_a_o,
   output logic              haz_b_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] pending_q, pending_d;
   logic             rsv_act, rs_live, rt_live;

   assign rsv_act = run_i && rsv_i && addr_live(int'(rsv_addr_i), DEPTH, ZERO_REG != 0);
   assign rs_live = addr_live(int'(rs_i), DEPTH, ZERO_REG != 0);
   assign rt_live = addr_live(int'(rt_i), DEPTH, ZERO_REG != 0);

   always_comb begin
      pending_d = pending_q;
      if (wr_i) begin
         pending_d[wr_addr_i[IDX_W-1:0]] = 1'b0;
      end
      // Applied last: a reservation is a newer producer than the write retiring this cycle.
      if (rsv_act) begin
         pending_d[rsv_addr_i[IDX_W-1:0]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign haz_a_o = run_i && rs_live && pending_q[rs_i[IDX_W-1:0]] && !(wr_i && (wr_addr_i == rs_i));
   assign haz_b_o = run_i && rt_live && pending_q[rt_i[IDX_W-1:0]] && !(wr_i && (wr_addr_i == rt_i));

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-first bypass, sequenced post-reset clear and hazard scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] dataIn,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic              rsv,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic [DATA_W-1:0] regA,
   output logic [DATA_W-1:0] regB,
   output logic              hazA,
   output logic              hazB,
   output logic              ready
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] regA_q, regA_d, regB_q, regB_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic run, wr_act, rs_live, rt_live;

   assign run     = (state_q == ST_RUN);
   assign wr_act  = run && we && addr_live(int'(rd), DEPTH, ZERO_REG != 0);
   assign rs_live = addr_live(int'(rs), DEPTH, ZERO_REG != 0);
   assign rt_live = addr_live(int'(rt), DEPTH, ZERO_REG != 0);

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      ready_d   = ready_q;
      regA_d    = '0;
      regB_d    = '0;
      unique case (state_q)
         ST_CLEAR: begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (rs_live) begin
               regA_d = (wr_act && (rd == rs)) ? dataIn : mem_q[rs[IDX_W-1:0]];
            end
            if (rt_live) begin
               regB_d = (wr_act && (rd == rt)) ? dataIn : mem_q[rt[IDX_W-1:0]];
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= '0;
         ready_q   <= 1'b0;
         regA_q    <= '0;
         regB_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         ready_q   <= ready_d;
         regA_q    <= regA_d;
         regB_q    <= regB_d;
      end
   end

   // Storage has no reset fan-out; the CLEAR walk zeroes one entry per cycle instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            mem_q[clr_idx_q[IDX_W-1:0]] <= '0;
         end else if (wr_act) begin
            mem_q[rd[IDX_W-1:0]] <= dataIn;
         end
      end
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .run_i      (run),
      .wr_i       (wr_act),
      .wr_addr_i  (rd),
      .rsv_i      (rsv),
      .rsv_addr_i (rsv_addr),
      .rs_i       (rs),
      .rt_i       (rt),
      .haz_a_o    (hazA),
      .haz_b_o    (hazB)
   );

   assign regA  = regA_q;
   assign regB  = regB_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against a behavioural array model.
module tb_regfile_sb;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 16;
   localparam int ZR    = 1;

   logic          clk = 1'b0;
   logic          rst, we, rsv;
   logic [AW-1:0] rd, rs, rt, rsv_addr;
   logic [DW-1:0] dataIn;
   logic [DW-1:0] regA, regB;
   logic          hazA, hazB, ready;

   always #5 clk = ~clk;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ZERO_REG(ZR)) dut (
      .clk(clk), .rst(rst), .we(we), .rd(rd), .dataIn(dataIn), .rs(rs), .rt(rt),
      .rsv(rsv), .rsv_addr(rsv_addr), .regA(regA), .regB(regB),
      .hazA(hazA), .hazB(hazB), .ready(ready)
   );

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] m_mem [32];
   bit            m_pend [32];
   int            clr_left;
   bit            m_ready;
   bit            known = 0;
   logic [DW-1:0] e_a, e_b;

   function automatic bit valid(input logic [AW-1:0] a);
      return (int'(a) < DEPTH) && !(ZR != 0 && a == 0);
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rdval(input logic [AW-1:0] a, input bit wr);
      if (!valid(a)) return '0;
      if (wr && rd == a) return dataIn;
      return m_mem[a];
   endfunction

   // Inputs are already driven; check hazards, advance the model, then check registered outputs.
   task automatic step();
      bit running, wr;
      #1;
      running = known && clr_left == 0;
      wr      = running && we && valid(rd);
      if (known) begin
         chk("hazA", {31'b0, hazA}, {31'b0, running && valid(rs) && m_pend[rs] && !(wr && rd == rs)});
         chk("hazB", {31'b0, hazB}, {31'b0, running && valid(rt) && m_pend[rt] && !(wr && rd == rt)});
      end
      if (rst) begin
         e_a = '0; e_b = '0;
         for (int i = 0; i < 32; i++) m_pend[i] = 0;
         clr_left = DEPTH; m_ready = 0; known = 1;
      end else if (clr_left > 0) begin
         m_mem[DEPTH - clr_left] = '0;
         clr_left--;
         if (clr_left == 0) m_ready = 1;
         e_a = '0; e_b = '0;
      end else begin
         e_a = rdval(rs, wr);
         e_b = rdval(rt, wr);
         if (wr) begin
            m_mem[rd]  = dataIn;
            m_pend[rd] = 0;
         end
         if (rsv && valid(rsv_addr)) m_pend[rsv_addr] = 1;
      end
      @(posedge clk);
      #1;
      chk("regA", regA, e_a);
      chk("regB", regB, e_b);
      chk("ready", {31'b0, ready}, {31'b0, m_ready});
      @(negedge clk);
   endtask

   task automatic drive(input bit w, input logic [AW-1:0] d, input logic [DW-1:0] din,
                        input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input bit r, input logic [AW-1:0] ra);
      we = w; rd = d; dataIn = din; rs = a; rt = b; rsv = r; rsv_addr = ra;
      step();
   endtask

   initial begin
      rst = 1'b1; we = 0; rsv = 0; rd = '0; rs = '0; rt = '0; rsv_addr = '0; dataIn = '0;
      @(negedge clk);
      step();
      rst = 1'b0;
      // Clear sequence, then a read of r5 must return 0.
      repeat (DEPTH + 2) drive(0, 0, 0, 5, 5, 0, 0);

      // Write-first bypass, then a plain read.
      drive(1, 5, 32'hDEADBEEF, 5, 5, 0, 0);
      drive(0, 0, 0, 5, 6, 0, 0);

      // Zero register ignores writes and reservations; out-of-range writes vanish.
      drive(1, 0, 32'h1234, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(1, 20, 32'hCAFE, 0, 20, 1, 20);
      drive(0, 0, 0, 20, 20, 0, 0);

      // Reserve, observe hazard, write resolves it in the same cycle.
      drive(0, 0, 0, 7, 7, 1, 7);
      drive(0, 0, 0, 7, 7, 0, 0);
      drive(1, 7, 32'h55, 7, 7, 0, 0);
      drive(0, 0, 0, 7, 7, 0, 0);

      // Same-cycle reserve and write: the reservation survives.
      drive(1, 9, 32'hAA, 9, 9, 1, 9);
      drive(0, 0, 0, 8, 9, 0, 0);

      // Reset in the middle of the clear walk; pulses during CLEAR must do nothing.
      rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      repeat (10) drive(1, 3, 32'h77, 3, 9, 1, 3);
      rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) drive(1, AW'(i), 32'hBAD0 + i, AW'(i), 3, 1, AW'(i));
      for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, AW'(i), AW'(DEPTH - 1 - i), 0, 0);

      // Random traffic with occasional resets.
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 149) == 0);
         drive($urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), $urandom,
               AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
               $urandom_range(0, 2) == 0, AW'($urandom_range(0, 31)));
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
